// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: port identifiers, the per-port
// access payload and the width of the burst run counter.
package dmem_arb_pkg;

   typedef enum logic {
      PORT_C = 1'b0,
      PORT_F = 1'b1
   } port_e;

   localparam int RUN_W = 4;

   // Payload fields are sized for the widest supported geometry; the top
   // casts to and from its own DATA_W / ADDR_W.
   localparam int REQ_ADDR_W = 16;
   localparam int REQ_DATA_W = 64;

   typedef struct packed {
      logic                  we;
      logic [REQ_ADDR_W-1:0] addr;
      logic [REQ_DATA_W-1:0] wdata;
   } mem_req_t;

   function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] run);
      return (run == '1) ? run : run + 1'b1;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
// The arbiter uses the slave modport; requesters plus memory form the master side.
interface dmem_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
);
   logic              c_req, c_we;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              f_req, f_we, f_lock;
   logic [ADDR_W-1:0] f_addr;
   logic [DATA_W-1:0] f_wdata;
   logic              c_gnt, f_gnt, c_rvalid, f_rvalid;
   logic [DATA_W-1:0] c_rdata, f_rdata;
   logic              mem_wr, mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wr_data, mem_rd_data;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      input  f_req, f_we, f_addr, f_wdata, f_lock,
      input  mem_rd_data,
      output c_gnt, f_gnt, c_rvalid, f_rvalid, c_rdata, f_rdata,
      output mem_wr, mem_rd, mem_addr, mem_wr_data
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      output f_req, f_we, f_addr, f_wdata, f_lock,
      output mem_rd_data,
      input  c_gnt, f_gnt, c_rvalid, f_rvalid, c_rdata, f_rdata,
      input  mem_wr, mem_rd, mem_addr, mem_wr_data
   );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way pick. Bit 0 of req_i/gnt_o is port C, bit 1 is port F.
// last_i is the port that keeps the bus when both request and no cap is hit.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  port_e      last_i,
   input  logic       burst_hit_i,
   input  logic       locked_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (locked_i) begin
         gnt_o = {req_i[1], 1'b0};
      end else if (req_i == 2'b01) begin
         gnt_o = 2'b01;
      end else if (req_i == 2'b10) begin
         gnt_o = 2'b10;
      end else if (req_i == 2'b11) begin
         if (burst_hit_i) gnt_o = (last_i == PORT_F) ? 2'b01 : 2'b10;
         else             gnt_o = (last_i == PORT_F) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core (C) and the
// fault-injection master (F), and routes one-cycle read data back to its owner.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 9,
   parameter int MAX_BURST = 4
) (
   input logic          clk,
   input logic          reset,
   dmem_arbiter_if.slave bus
);

   port_e            last_q, last_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             locked_q, locked_d;
   logic             idle_q, idle_d;
   logic [1:0]       rd_owner_q, rd_owner_d;

   logic [1:0] pick_gnt, gnt;
   port_e      pref, winner;
   logic       lock_eff, burst_hit;
   mem_req_t   c_r, f_r, win_r;

   // A lock only holds while f_lock stays high, so C can win in the drop cycle.
   assign lock_eff  = locked_q & bus.f_lock;
   assign burst_hit = (run_q >= RUN_W'(MAX_BURST));
   // After an idle cycle the other port gets first turn.
   assign pref      = idle_q ? port_e'(~last_q) : last_q;

   rr_pick2 u_pick (
      .req_i      ({bus.f_req, bus.c_req}),
      .last_i     (pref),
      .burst_hit_i(burst_hit),
      .locked_i   (lock_eff),
      .gnt_o      (pick_gnt)
   );

   assign gnt       = reset ? pick_gnt : 2'b00;
   assign winner    = gnt[1] ? PORT_F : PORT_C;
   assign bus.c_gnt = gnt[0];
   assign bus.f_gnt = gnt[1];

   always_comb begin
      c_r   = '{we: bus.c_we, addr: REQ_ADDR_W'(bus.c_addr), wdata: REQ_DATA_W'(bus.c_wdata)};
      f_r   = '{we: bus.f_we, addr: REQ_ADDR_W'(bus.f_addr), wdata: REQ_DATA_W'(bus.f_wdata)};
      win_r = '0;
      if (gnt[0])      win_r = c_r;
      else if (gnt[1]) win_r = f_r;
   end

   assign bus.mem_wr      = (|gnt) &  win_r.we;
   assign bus.mem_rd      = (|gnt) & ~win_r.we;
   assign bus.mem_addr    = ADDR_W'(win_r.addr);
   assign bus.mem_wr_data = DATA_W'(win_r.wdata);

   assign bus.c_rvalid = rd_owner_q[0] & reset;
   assign bus.f_rvalid = rd_owner_q[1] & reset;
   assign bus.c_rdata  = bus.c_rvalid ? bus.mem_rd_data : '0;
   assign bus.f_rdata  = bus.f_rvalid ? bus.mem_rd_data : '0;

   always_comb begin
      last_d     = last_q;
      run_d      = run_q;
      locked_d   = locked_q;
      idle_d     = 1'b0;
      rd_owner_d = gnt & {2{~win_r.we}};
      if (gnt == 2'b00) begin
         run_d  = '0;
         idle_d = 1'b1;
      end else if (winner == last_q) begin
         run_d = run_inc(run_q);
      end else begin
         run_d  = RUN_W'(1);
         last_d = winner;
      end
      if (gnt[1] && bus.f_lock) locked_d = 1'b1;
      else if (!bus.f_lock)     locked_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_q     <= PORT_C;
         run_q      <= '0;
         locked_q   <= 1'b0;
         idle_q     <= 1'b0;
         rd_owner_q <= 2'b00;
      end else begin
         last_q     <= last_d;
         run_q      <= run_d;
         locked_q   <= locked_d;
         idle_q     <= idle_d;
         rd_owner_q <= rd_owner_d;
      end
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port 512-word data memory between the RISC-V core's load/store path (port C) and the fault-injection master (port F). It grants at most one access per cycle and muxes the winner onto the memory bus. It returns read data with the memory's one-cycle latency, tagged to the correct requester. Round-robin arbitration, a burst cap and an F-side lock allow atomic read-modify-write bit flips.

## Interface

**Parameters**
- DATA_W, 32: data width.
- ADDR_W, 9: word address width.
- MAX_BURST, 4: maximum consecutive grants to one port while the other is requesting. Legal range 1..15.

**Ports**
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-low.
- c_req / f_req, input, 1 each: access request. Held with payload until granted.
- c_we / f_we, input, 1 each: 1 = write, 0 = read.
- c_addr / f_addr, input, ADDR_W each: word address.
- c_wdata / f_wdata, input, DATA_W each: write data.
- f_lock, input, 1: F holds the bus across consecutive accesses.
- c_gnt / f_gnt, output, 1 each: access accepted this cycle.
- c_rvalid / f_rvalid, output, 1 each: read data valid, one cycle after a read grant.
- c_rdata / f_rdata, output, DATA_W each: read data, qualified by rvalid.
- mem_wr, mem_rd, output, 1 each: memory strobes.
- mem_addr, output, ADDR_W: memory address.
- mem_wr_data, output, DATA_W: memory write data.
- mem_rd_data, input, DATA_W: memory read data, valid one cycle after mem_rd.

## Operation

- **Grants.** Grant decision is combinational from the current requests and registered state. At most one of c_gnt / f_gnt is high. A grant is never given without its req.
- **Memory drive.** The granted port's we/addr/wdata drive mem_*.
  - mem_wr = gnt & we.
  - mem_rd = gnt & ~we.
  - With no grant: mem_wr = mem_rd = 0 and mem_addr = 0.
- **Registered state.**
  - last (1 bit, last granted port).
  - run (4 bits, consecutive grants to `last`).
  - locked (1 bit).
  - rd_owner (2 bits, one-hot, the pending read's port).
- **Arbitration, evaluated in priority order:**
  1. If locked and f_req: grant F.
  2. If only one port requests: grant it.
  3. If both request and run ≥ MAX_BURST: grant the port that is not `last`.
  4. If both request: grant `last` (run continuation). After a cycle with no grant, grant the port that is not `last` (round-robin).
- **run update on a grant.**
  - Same port as `last`: run increments, saturating at 15.
  - Otherwise: run = 1, last = winner.
  - A cycle with no grant clears run to 0.
- **Lock.**
  - locked sets on an F grant with f_lock = 1.
  - locked clears on the first cycle with f_lock = 0.
  - While locked, C is never granted, even if f_req is low. A C request stalls.
- **Read return.**
  - rd_owner captures the read grant each cycle.
  - x_rvalid = rd_owner[x].
  - x_rdata = mem_rd_data when x_rvalid, else 0.
- **Overlap.** A write granted in the cycle after a read does not disturb that read's return.

## Timing

- **Reset values** (reset = 0 at a clock edge):
  - last = C, run = 0, locked = 0, rd_owner = 0.
  - All gnt, rvalid, mem_wr and mem_rd are 0 while reset is low, including combinational outputs.
  - rdata outputs are 0.
- **Latency.**
  - Grant: 0 cycles from req, same cycle.
  - Read data: rvalid exactly 1 cycle after the read grant.
  - Write: completes at the grant edge.
- **Throughput.** One access per cycle. Back-to-back grants to the same port are allowed.
- **Reset mid-read.** A pending rvalid is squashed.
- **Reset while locked.** Lock is released.
- **Simultaneous requests from reset.** C wins, because last = C and run = 0 < MAX_BURST.
- **Lock release.** f_lock dropping and a C request in the same cycle: C is granted that cycle.

## Structure

- Package `dmem_arb_pkg`:
  - Typedef `port_e` with values PORT_C = 0 and PORT_F = 1.
  - Typedef `mem_req_t` struct {we, addr, wdata}.
  - Constant RUN_W = 4.
- **Sub-module `rr_pick2`.** Combinational two-way pick from {req pair, last, run ≥ MAX_BURST, locked}, output one-hot.
- Top level holds the state registers, the memory mux and the read-return routing.

## Test plan

- **Reset.** Hold reset = 0 for 3 cycles with c_req = f_req = 1 → all gnt, rvalid, mem_rd and mem_wr are 0. Release with both still requesting → c_gnt in the first cycle.
- **Single port.** C reads addr 0x010 with memory returning 0xDEADBEEF → c_gnt same cycle; next cycle c_rvalid = 1 and c_rdata = 0xDEADBEEF; f_rvalid stays 0.
- **Burst cap.** Both request continuously, MAX_BURST = 4 → grant sequence C,C,C,C,F,F,F,F,C…
- **Lock / RMW.** F reads 0x1FF with f_lock = 1, then writes 0x1FF = 0x00000004 while C requests throughout → C is stalled until f_lock drops. The cycle f_lock drops, c_gnt = 1.
- **Read then write.** F reads 0x020 (memory returns 0x12345678), then C writes 0x021 on the next cycle → f_rvalid = 1 with f_rdata = 0x12345678 in the same cycle as mem_wr = 1 with mem_addr = 0x021.
- **Reset mid-read.** A read is granted to C and reset asserts on the next edge → c_rvalid stays 0 and locked is 0.
